wb_spi_seq: RTL

WB_SPI_SEQ -- requirements
Module: wb_spi_seq

---
 rtl/wb_spi_seq_pkg.sv | 26 ++
 rtl/wb_spi_seq_bus.sv | 50 +++++
 rtl/wb_spi_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/wb_spi_seq_pkg.sv
// Shared constants for the Wishbone SPI byte sequencer: SPI master register map,
// SPSR flag positions and the sequencer state encoding.
package wb_spi_seq_pkg;

    localparam logic [2:0] REG_SPCR = 3'd0;
    localparam logic [2:0] REG_SPSR = 3'd1;
    localparam logic [2:0] REG_SPDR = 3'd2;
    localparam logic [2:0] REG_SPER = 3'd3;
    localparam logic [2:0] REG_SSCS = 3'd4;

    localparam int unsigned SPSR_RFEMPTY = 0;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_CS_ON,
        ST_TX_WAIT,
        ST_WR_DR,
        ST_POLL,
        ST_RD_DR,
        ST_RX_PUSH,
        ST_CS_OFF,
        ST_FIN
    } state_t;

endpackage

// File: rtl/wb_spi_seq_bus.sv
// Single-access Wishbone master: runs one read or write per request and pulses
// done for one cycle with the read data registered alongside it.
module wb_spi_seq_bus (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       we,
    input  logic [2:0] adr,
    input  logic [7:0] wdata,
    output logic       done,
    output logic [7:0] rdata,
    output logic       wbm_cyc_o,
    output logic       wbm_stb_o,
    output logic       wbm_we_o,
    output logic [2:0] wbm_adr_o,
    output logic [7:0] wbm_dat_o,
    input  logic [7:0] wbm_dat_i,
    input  logic       wbm_ack_i
);

    assign wbm_stb_o = wbm_cyc_o;

    // A request still held during the done cycle belongs to the finished access,
    // so a new cycle only starts once done has cleared; cyc stays low in between.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbm_cyc_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            done      <= 1'b0;
            rdata     <= '0;
        end else begin
            done <= 1'b0;
            if (wbm_cyc_o) begin
                if (wbm_ack_i) begin
                    wbm_cyc_o <= 1'b0;
                    done      <= 1'b1;
                    rdata     <= wbm_dat_i;
                end
            end else if (req && !done) begin
                wbm_cyc_o <= 1'b1;
                wbm_we_o  <= we;
                wbm_adr_o <= adr;
                wbm_dat_o <= wdata;
            end
        end
    end

endmodule

// File: rtl/wb_spi_seq.sv
// Byte-stream sequencer driving a Wishbone SPI master: initialises it, then for
// each command selects a slave, shifts len+1 bytes one at a time and deselects.
module wb_spi_seq
    import wb_spi_seq_pkg::*;
#(
    parameter int          SPI_SLAVE = 1,
    parameter logic [7:0]  SPCR_INIT = 8'h50,
    parameter int          POLL_MAX  = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [7:0]           cmd_len_i,
    input  logic [SPI_SLAVE-1:0] cmd_cs_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    input  logic [7:0]           tx_data_i,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic [7:0]           rx_data_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic [2:0]           wbm_adr_o,
    output logic [7:0]           wbm_dat_o,
    input  logic [7:0]           wbm_dat_i,
    input  logic                 wbm_ack_i
);

    localparam int PCW = $clog2(POLL_MAX + 1);

    state_t               state, state_next;
    logic                 init_step;
    logic [7:0]           remaining;
    logic [SPI_SLAVE-1:0] cs_q;
    logic [7:0]           tx_byte;
    logic [PCW-1:0]       poll_cnt;

    logic       bus_req, bus_we, bus_done;
    logic [2:0] bus_adr;
    logic [7:0] bus_wdata, bus_rdata;

    wb_spi_seq_bus u_bus (
        .clk       (clk_i),
        .rst       (rst_i),
        .req       (bus_req),
        .we        (bus_we),
        .adr       (bus_adr),
        .wdata     (bus_wdata),
        .done      (bus_done),
        .rdata     (bus_rdata),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_INIT;
        else       state <= state_next;
    end

    // busy_o is registered from the next state so it reads 0 in the cycle after reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            init_step <= 1'b0;
            remaining <= '0;
            cs_q      <= '0;
            tx_byte   <= '0;
            poll_cnt  <= '0;
            rx_data_o <= '0;
            busy_o    <= 1'b0;
        end else begin
            busy_o <= (state_next != ST_IDLE);
            case (state)
                ST_INIT:    if (bus_done) init_step <= 1'b1;
                ST_IDLE:    if (cmd_valid_i) begin
                                remaining <= cmd_len_i;
                                cs_q      <= cmd_cs_i;
                            end
                ST_TX_WAIT: if (tx_valid_i) tx_byte <= tx_data_i;
                ST_WR_DR:   poll_cnt <= '0;
                ST_POLL:    if (bus_done && bus_rdata[SPSR_RFEMPTY]) poll_cnt <= poll_cnt + 1'b1;
                ST_RD_DR:   if (bus_done) rx_data_o <= bus_rdata;
                ST_RX_PUSH: if (rx_ready_i && remaining != 8'd0) remaining <= remaining - 8'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        bus_req     = 1'b0;
        bus_we      = 1'b1;
        bus_adr     = REG_SPCR;
        bus_wdata   = '0;
        cmd_ready_o = 1'b0;
        tx_ready_o  = 1'b0;
        rx_valid_o  = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        case (state)
            ST_INIT: begin
                bus_req   = 1'b1;
                bus_adr   = init_step ? REG_SPER : REG_SPCR;
                bus_wdata = init_step ? 8'h00 : SPCR_INIT;
                if (bus_done && init_step) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) state_next = ST_CS_ON;
            end
            ST_CS_ON: begin
                bus_req   = 1'b1;
                bus_adr   = REG_SSCS;
                bus_wdata = 8'(cs_q);
                if (bus_done) state_next = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                tx_ready_o = 1'b1;
                if (tx_valid_i) state_next = ST_WR_DR;
            end
            ST_WR_DR: begin
                bus_req   = 1'b1;
                bus_adr   = REG_SPDR;
                bus_wdata = tx_byte;
                if (bus_done) state_next = ST_POLL;
            end
            ST_POLL: begin
                bus_req = 1'b1;
                bus_we  = 1'b0;
                bus_adr = REG_SPSR;
                if (bus_done) begin
                    if (!bus_rdata[SPSR_RFEMPTY]) begin
                        state_next = ST_RD_DR;
                    end else if (poll_cnt == PCW'(POLL_MAX - 1)) begin
                        err_o      = 1'b1;
                        state_next = ST_CS_OFF;
                    end
                end
            end
            ST_RD_DR: begin
                bus_req = 1'b1;
                bus_we  = 1'b0;
                bus_adr = REG_SPDR;
                if (bus_done) state_next = ST_RX_PUSH;
            end
            ST_RX_PUSH: begin
                rx_valid_o = 1'b1;
                if (rx_ready_i) state_next = (remaining == 8'd0) ? ST_CS_OFF : ST_TX_WAIT;
            end
            ST_CS_OFF: begin
                bus_req   = 1'b1;
                bus_adr   = REG_SSCS;
                bus_wdata = 8'h00;
                if (bus_done) state_next = ST_FIN;
            end
            ST_FIN: begin
                done_o     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_INIT;
        endcase
    end

endmodule
